diff_window_accum: RTL

//  Downstream consumer of the 8-bit subtractor output (uo_out = ui_in - uio_in).

---
 rtl/diff_window_accum_if.sv | 39 +++
 rtl/diff_window_accum.sv | 110 +++++++++++
 2 files changed

// File: rtl/diff_window_accum_if.sv
// Stream bundle between a difference-byte producer and diff_window_accum.
// The min_out/max_out trackers are present only when DIFF_WIN_MINMAX_EN is defined.
interface diff_window_accum_if #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned ACC_W  = 12
);
  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  logic             start;
  logic             diff_valid;
  logic [7:0]       diff_in;
  logic [ACC_W-1:0] sum_out;
  logic [CNT_W-1:0] count_out;
  logic             busy;
  logic             done;
  logic             sat;
`ifdef DIFF_WIN_MINMAX_EN
  logic [7:0]       min_out;
  logic [7:0]       max_out;

  modport master (
    output start, diff_valid, diff_in,
    input  sum_out, count_out, busy, done, sat, min_out, max_out
  );
  modport slave (
    input  start, diff_valid, diff_in,
    output sum_out, count_out, busy, done, sat, min_out, max_out
  );
`else
  modport master (
    output start, diff_valid, diff_in,
    input  sum_out, count_out, busy, done, sat
  );
  modport slave (
    input  start, diff_valid, diff_in,
    output sum_out, count_out, busy, done, sat
  );
`endif
endinterface

// File: rtl/diff_window_accum.sv
// Windowed saturating accumulator of signed difference bytes with done pulse.
// Optional running min/max trackers enabled by macro DIFF_WIN_MINMAX_EN.
module diff_window_accum #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned ACC_W  = 12
) (
  input logic                 clk,
  input logic                 rst,
  diff_window_accum_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_sat;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_last;
  logic signed [ACC_W:0] w_sum_wide;
  logic             w_ovf;
  logic [ACC_W-1:0] w_sum_sat;

  // start overrides diff_valid, so a restart cycle never accepts a sample
  assign w_accept = (r_state == S_RUN) && bus.diff_valid && !bus.start;
  assign w_last   = (r_count == CNT_W'(WINDOW - 1));

  // One guard bit: overflow shows up as disagreement of the top two bits
  assign w_sum_wide = (ACC_W+1)'($signed(r_sum)) + (ACC_W+1)'($signed(bus.diff_in));
  assign w_ovf      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
  assign w_sum_sat  = !w_ovf ? w_sum_wide[ACC_W-1:0]
                             : (w_sum_wide[ACC_W] ? SUM_MIN : SUM_MAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (bus.start) begin
        r_sum   <= '0;
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (w_accept) begin
        r_sum   <= w_sum_sat;
        r_count <= r_count + CNT_W'(1);
        if (w_ovf) r_sat <= 1'b1;
      end
    end
  end

  assign bus.sum_out   = r_sum;
  assign bus.count_out = r_count;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sat       = r_sat;

`ifdef DIFF_WIN_MINMAX_EN
  logic [7:0] r_min;
  logic [7:0] r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min <= '0;
      r_max <= '0;
    end else if (bus.start) begin
      r_min <= 8'h7F;
      r_max <= 8'h80;
    end else if (w_accept) begin
      if ($signed(bus.diff_in) < $signed(r_min)) r_min <= bus.diff_in;
      if ($signed(bus.diff_in) > $signed(r_max)) r_max <= bus.diff_in;
    end
  end

  assign bus.min_out = r_min;
  assign bus.max_out = r_max;
`endif
endmodule
